// File: rtl/serial_fetch_responder.sv
// Serial program-memory responder: takes a 16-bit address MSB first, looks it up in
// an internal program store and returns the instruction word LSB first.
module serial_fetch_responder #(
  parameter int          DEPTH      = 256,
  parameter int          TURNAROUND = 2,
  parameter logic [15:0] FILL       = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sync,
  input  logic        addr_in,
  input  logic        wr_en,
  input  logic [15:0] wr_addr,
  input  logic [15:0] wr_data,
  output logic        data_out,
  output logic        data_valid,
  output logic        last,
  output logic        busy,
  output logic        frame_err
);

  localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [16:0] DEPTH_LIM = 17'(DEPTH);
  localparam logic [3:0]  TA_LAST   = 4'(TURNAROUND - 1);

  typedef enum logic [1:0] {IDLE, ADDR, LOOKUP, DATA} stateT;

  stateT       state, stateNext;
  logic [15:0] addrReg, addrNext;
  logic [3:0]  bitCnt, bitCntNext;
  logic [3:0]  taCnt, taCntNext;
  logic [15:0] wordReg, wordNext;
  logic [3:0]  outCnt, outCntNext;
  logic        dataOutNext, dataValidNext, lastNext, busyNext, frameErrNext;

  logic [15:0] mem [DEPTH];
  logic        rdInRange, wrInRange;
  logic [15:0] rdWord;

  // The full 16-bit address is range-checked; out-of-range never aliases to low words.
  assign rdInRange = {1'b0, addrReg} < DEPTH_LIM;
  assign wrInRange = {1'b0, wr_addr} < DEPTH_LIM;
  assign rdWord    = rdInRange ? mem[addrReg[AW-1:0]] : FILL;

  // NOTE: the program store has no reset; it keeps its contents across rst.
  always_ff @(posedge clk) begin
    if (!rst && wr_en && wrInRange) begin
      mem[wr_addr[AW-1:0]] <= wr_data;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    stateNext     = state;
    addrNext      = addrReg;
    bitCntNext    = bitCnt;
    taCntNext     = taCnt;
    wordNext      = wordReg;
    outCntNext    = outCnt;
    dataOutNext   = data_out;
    dataValidNext = data_valid;
    lastNext      = last;
    frameErrNext  = 1'b0;

    unique case (state)
      IDLE: begin
        if (sync) begin
          stateNext  = ADDR;
          addrNext   = {15'b0, addr_in};
          bitCntNext = 4'd1;
        end
      end
      ADDR: begin
        addrNext = {addrReg[14:0], addr_in};
        if (bitCnt == 4'd15) begin
          stateNext = LOOKUP;
          taCntNext = 4'd0;
        end else begin
          bitCntNext = bitCnt + 4'd1;
        end
      end
      LOOKUP: begin
        if (taCnt == TA_LAST) begin
          stateNext     = DATA;
          wordNext      = rdWord;
          dataOutNext   = rdWord[0];
          dataValidNext = 1'b1;
          lastNext      = 1'b0;
          outCntNext    = 4'd0;
        end else begin
          taCntNext = taCnt + 4'd1;
        end
      end
      DATA: begin
        if (outCnt == 4'd15) begin
          stateNext     = IDLE;
          dataOutNext   = 1'b0;
          dataValidNext = 1'b0;
          lastNext      = 1'b0;
        end else begin
          wordNext    = {1'b0, wordReg[15:1]};
          dataOutNext = wordReg[1];
          outCntNext  = outCnt + 4'd1;
          lastNext    = (outCnt == 4'd14);
        end
      end
    endcase

    // A sync on the edge that would end DATA is a legal back-to-back start.
    if (sync && state != IDLE) begin
      frameErrNext  = !(state == DATA && outCnt == 4'd15);
      stateNext     = ADDR;
      addrNext      = {15'b0, addr_in};
      bitCntNext    = 4'd1;
      dataOutNext   = 1'b0;
      dataValidNext = 1'b0;
      lastNext      = 1'b0;
    end

    busyNext = (stateNext != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      addrReg    <= '0;
      bitCnt     <= '0;
      taCnt      <= '0;
      wordReg    <= '0;
      outCnt     <= '0;
      data_out   <= 1'b0;
      data_valid <= 1'b0;
      last       <= 1'b0;
      busy       <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
      state      <= stateNext;
      addrReg    <= addrNext;
      bitCnt     <= bitCntNext;
      taCnt      <= taCntNext;
      wordReg    <= wordNext;
      outCnt     <= outCntNext;
      data_out   <= dataOutNext;
      data_valid <= dataValidNext;
      last       <= lastNext;
      busy       <= busyNext;
      frame_err  <= frameErrNext;
    end
  end

endmodule

// File: tb/tb_serial_fetch_responder.sv
// Self-checking bench for serial_fetch_responder: directed scenarios plus randomized
// frames, compared cycle by cycle against a frame-timing reference model.
module tb_serial_fetch_responder;

  localparam int          DEPTH = 256;
  localparam int          T     = 2;
  localparam logic [15:0] FILL  = 16'h0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sync = 1'b0, addr_in = 1'b0, wr_en = 1'b0;
  logic [15:0] wr_addr = '0, wr_data = '0;
  logic        data_out, data_valid, last, busy, frame_err;

  serial_fetch_responder #(.DEPTH(DEPTH), .TURNAROUND(T), .FILL(FILL)) dut (
    .clk(clk), .rst(rst), .sync(sync), .addr_in(addr_in), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .data_out(data_out),
    .data_valid(data_valid), .last(last), .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nBad    = 0;
  int edgeNo  = 0;

  // Reference model: frame position k = edges since the accepted sync.
  logic [15:0] refMem [DEPTH];
  bit          active    = 1'b0;
  int          startEdge = 0;
  logic [15:0] refAddr   = '0;
  logic [15:0] refWord   = '0;
  logic        eBusy = 1'b0, eValid = 1'b0, eLast = 1'b0, eData = 1'b0, eErr = 1'b0;
  logic [15:0] shiftIn = '0;
  bit          randWr  = 1'b0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nBad++;
      $display("FAIL %s @edge %0d: got %h expected %h", tag, edgeNo, obs, exp);
    end
  endtask

  task automatic modelEdge(input logic s, input logic a, input logic we,
                           input logic [15:0] wa, input logic [15:0] wd);
    int k;
    if (rst) begin
      active = 1'b0;
      {eBusy, eValid, eLast, eData, eErr} = '0;
      return;
    end
    eErr = 1'b0;
    k = edgeNo - startEdge;
    if (s) begin
      if (active && k >= 1 && k <= 30 + T) eErr = 1'b1;
      startEdge = edgeNo;
      active    = 1'b1;
      refAddr   = {15'b0, a};
      k         = 0;
    end else if (active) begin
      if (k <= 15) refAddr = {refAddr[14:0], a};
      if (k == 15 + T) refWord = (refAddr < DEPTH) ? refMem[refAddr[7:0]] : FILL;
      if (k > 30 + T) active = 1'b0;
    end
    if (we && wa < DEPTH) refMem[wa[7:0]] = wd;
    eBusy  = active && k <= 30 + T;
    eValid = active && k >= 15 + T && k <= 30 + T;
    eLast  = active && k == 30 + T;
    eData  = eValid ? refWord[k - 15 - T] : 1'b0;
  endtask

  task automatic step(input logic s, input logic a, input logic we,
                      input logic [15:0] wa, input logic [15:0] wd);
    sync = s; addr_in = a; wr_en = we; wr_addr = wa; wr_data = wd;
    @(posedge clk);
    edgeNo++;
    modelEdge(s, a, we, wa, wd);
    @(negedge clk);
    if (data_valid) shiftIn = {data_out, shiftIn[15:1]};
    check("cycle", 16'({busy, data_valid, last, data_out & eValid, frame_err}),
          16'({eBusy, eValid, eLast, eData, eErr}));
  endtask

  task automatic pickWrite(output logic we, output logic [15:0] wa, output logic [15:0] wd);
    we = randWr && ($urandom_range(0, 2) == 0);
    wa = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 15));
    wd = 16'($urandom);
  endtask

  task automatic idle(input int n);
    logic we;
    logic [15:0] wa, wd;
    for (int i = 0; i < n; i++) begin
      pickWrite(we, wa, wd);
      step(1'b0, 1'($urandom), we, wa, wd);
    end
  endtask

  task automatic writeWord(input logic [15:0] wa, input logic [15:0] wd);
    step(1'b0, 1'b0, 1'b1, wa, wd);
  endtask

  // cut < 16 abandons the address phase; tail = cycles after the 16th address bit.
  task automatic sendFrame(input logic [15:0] a, input int cut, input int tail,
                           input bit colWr, input logic [15:0] colData);
    logic we;
    logic [15:0] wa, wd;
    for (int i = 0; i < cut; i++) begin
      pickWrite(we, wa, wd);
      step(i == 0, a[15-i], we, wa, wd);
    end
    if (cut == 16) begin
      for (int j = 0; j < tail; j++) begin
        pickWrite(we, wa, wd);
        if (colWr && j == T - 1) begin
          we = 1'b1; wa = a; wd = colData;
        end
        step(1'b0, 1'($urandom), we, wa, wd);
      end
    end
  endtask

  logic [15:0] fa;
  int          fr;

  initial begin
    #1 rst = 1'b1;
    #1 check("reset_state", 16'({busy, data_valid, last, data_out, frame_err}), 16'h0000);
    @(negedge clk);
    step(1'b1, 1'b1, 1'b0, '0, '0);
    step(1'b0, 1'b0, 1'b0, '0, '0);
    rst = 1'b0;

    for (int i = 0; i < DEPTH; i++) writeWord(16'(i), 16'($urandom));

    // Basic fetch
    writeWord(16'h0012, 16'hA5C3);
    sendFrame(16'h0012, 16, 16 + T, 1'b0, '0);
    check("basic_word", shiftIn, 16'hA5C3);
    idle(2);

    // Out of range: no alias on read or write
    writeWord(16'h0000, 16'h5A5A);
    writeWord(16'h0100, 16'hBEEF);
    sendFrame(16'h0100, 16, 16 + T, 1'b0, '0);
    check("oor_fill", shiftIn, FILL);
    sendFrame(16'h0000, 16, 16 + T, 1'b0, '0);
    check("oor_no_alias", shiftIn, 16'h5A5A);

    // Back-to-back frames
    writeWord(16'h0020, 16'h1111);
    writeWord(16'h0021, 16'h2222);
    sendFrame(16'h0020, 16, 15 + T, 1'b0, '0);
    check("b2b_first", shiftIn, 16'h1111);
    sendFrame(16'h0021, 16, 16 + T, 1'b0, '0);
    check("b2b_second", shiftIn, 16'h2222);

    // Mid-frame sync at E20
    writeWord(16'h0003, 16'h0001);
    sendFrame(16'h0012, 16, 4, 1'b0, '0);
    sendFrame(16'h0003, 16, 16 + T, 1'b0, '0);
    check("mid_word", shiftIn, 16'h0001);

    // Write collision on the lookup edge
    writeWord(16'h0040, 16'h1234);
    sendFrame(16'h0040, 16, 16 + T, 1'b1, 16'hFFFF);
    check("col_old", shiftIn, 16'h1234);
    sendFrame(16'h0040, 16, 16 + T, 1'b0, '0);
    check("col_new", shiftIn, 16'hFFFF);

    // Randomized frames with background writes, aborts and back-to-back starts
    randWr = 1'b1;
    for (int f = 0; f < 60; f++) begin
      fa = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 15));
      fr = $urandom_range(0, 9);
      if (fr == 0)      sendFrame(fa, $urandom_range(1, 15), 0, 1'b0, '0);
      else if (fr == 1) sendFrame(fa, 16, $urandom_range(0, 14 + T), 1'b0, '0);
      else if (fr <= 5) sendFrame(fa, 16, 15 + T, 1'b0, '0);
      else              sendFrame(fa, 16, 16 + T + $urandom_range(0, 3), 1'b0, '0);
    end
    randWr = 1'b0;
    idle(40);

    // Async reset during DATA
    writeWord(16'h0012, 16'hA5C3);
    sendFrame(16'h0012, 16, T + 5, 1'b0, '0);
    #2 rst = 1'b1;
    #1 check("rst_async", 16'({busy, data_valid, last, data_out, frame_err}), 16'h0000);
    active = 1'b0;
    {eBusy, eValid, eLast, eData, eErr} = '0;
    @(negedge clk);
    writeWord(16'h0012, 16'h0BAD);
    step(1'b1, 1'b1, 1'b0, '0, '0);
    rst = 1'b0;
    idle(40);
    check("rst_no_valid", 16'(data_valid), 16'h0000);
    sendFrame(16'h0012, 16, 16 + T, 1'b0, '0);
    check("rst_wr_ignored", shiftIn, 16'hA5C3);
    idle(2);

    $display("test done: total=%0d bad=%0d", nChecks, nBad);
    $finish;
  end

endmodule

// File: doc/serial_fetch_responder.md
# serial_fetch_responder

Serial program-memory responder that sits directly upstream of the opcode fetch stage. It receives a 16-bit instruction address as a serial bit stream, MSB first, and looks the word up in an internal program store. It then returns the 16-bit instruction serially, LSB first, for the fetch stage to shift in. A parallel write port lets the loader/testbench fill the program store.

## Interface
Parameters:
- DEPTH, 256: program store size in 16-bit words; address bits used = clog2(DEPTH).
- TURNAROUND, 2: LOOKUP cycles between the last address bit and the first data bit; legal range 1..15.
- FILL, 16'h0000: word returned for addresses >= DEPTH.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- sync  in  1  frame start; high in the cycle carrying address bit 15.
- addr_in  in  1  serial address bit, MSB first.
- wr_en  in  1  program-store write strobe.
- wr_addr  in  16  write address; writes to addresses >= DEPTH are dropped.
- wr_data  in  16  write data.
- data_out  out  1  serial instruction bit, LSB first, registered.
- data_valid  out  1  high while data_out carries an instruction bit.
- last  out  1  high with instruction bit 15.
- busy  out  1  high in ADDR, LOOKUP and DATA states.
- frame_err  out  1  one-cycle pulse when sync arrives outside IDLE.

## Operation
- Reset: all outputs 0, state IDLE, counters 0, address shift register 0. The program store is not cleared, and writes are ignored while rst is high.
- States:
  - IDLE: a sample of sync=1 captures addr_in as A[15], sets bit count to 1, and moves to ADDR. sync=0 keeps the block in IDLE.
  - ADDR: shift addr_in into the address register (MSB first). After A[0] is sampled (16th bit), move to LOOKUP with the turnaround count at 0.
  - LOOKUP: count TURNAROUND edges. On the last one, read the store, latch the word into the output shift register, drive data_out<=W[0] and data_valid<=1, and move to DATA.
  - DATA: shift the word out one bit per edge, LSB first. After W[15] has been driven for one cycle, clear data_valid/last and return to IDLE.
- Address decode: the full 16 bits are compared against DEPTH. An address >= DEPTH returns FILL; there is no wrap to the low bits.
- Write port: a synchronous write on each edge with wr_en=1, in any state.
  - A write at the same address on the same edge as the LOOKUP read is not visible; that read returns the old word.
  - Writes during DATA never alter the word being shifted out.
- sync in ADDR, LOOKUP or DATA:
  - frame_err pulses for one cycle.
  - The current frame is abandoned immediately: data_valid and last go to 0 on that edge.
  - The sampled bit is taken as A[15] of a new frame, and the block continues in ADDR with count 1.
- sync is ignored on its own edge in every other respect. addr_in is don't-care in IDLE without sync, and in LOOKUP and DATA.
- busy = (state != IDLE), registered with the state.

## Timing
- Edge E0 samples sync=1 and A[15]; edges E1..E15 sample A[14..0].
- LOOKUP occupies edges E16..E(15+T), where T = TURNAROUND.
- After edge E(15+T+i), data_out = W[i] for i = 0..15, and data_valid = 1.
  - last = 1 only after E(30+T).
  - After E(31+T): data_valid = 0, last = 0, busy = 0, state IDLE.
- First data bit latency: 15+T edges after the sync edge. Frame length: 32+T cycles.
- Back-to-back frames: a sync sampled at E(31+T) is accepted as a new frame without error. A sync sampled at any edge E1..E(30+T) is a frame_err.
- frame_err is registered: high for exactly the cycle after the offending edge.
- Async reset mid-frame forces all outputs low immediately, without waiting for a clock edge. The first frame after release needs a fresh sync.

## Test plan
- Basic fetch, T=2:
  - Stimulus: write 16'hA5C3 to address 16'h0012, then send address 16'h0012 with sync.
  - Required: data_out = 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 after E17..E32; last only after E32; busy 0 after E33.
- Out of range, DEPTH=256:
  - Stimulus: address 16'h0100.
  - Required: returns FILL (16'h0000); no alias to address 0.
- Back-to-back frames:
  - Stimulus: second sync sampled at E33.
  - Required: no frame_err; second word begins after E50.
- Mid-frame sync:
  - Stimulus: sync sampled at E20 with a new address 16'h0003 (mem[3]=16'h0001).
  - Required: frame_err high one cycle; data_valid 0 after E20; new word 16'h0001 emitted starting after E37.
- Write collision:
  - Stimulus: write 16'hFFFF to the frame's address on the edge of the LOOKUP read.
  - Required: old word returned. The next frame to the same address returns 16'hFFFF.
- Async reset:
  - Stimulus: assert rst between edges during DATA.
  - Required: all outputs 0 immediately. After release with no sync, data_valid stays 0.
